// File: rtl/pc_pkg.sv
// Shared fetch-stage constants and the redirect-buffer state/control types.
// W is also used by the IF/ID pipeline register and CP0.
package pc_pkg;

    localparam int unsigned PC_W         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
    localparam logic [31:0] IM_LO_DEF    = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEF    = 32'h0000_6FFC;

    typedef enum logic {
        BUF_IDLE,
        BUF_HELD
    } buf_state_t;

    typedef enum logic [1:0] {
        BUF_HOLD,
        BUF_LOAD,
        BUF_CLEAR
    } buf_op_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds a redirect that arrived while fetch was stalled until the stall lifts.
// op selects load (capture target, go HELD), clear (go IDLE) or hold.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int unsigned W = PC_W
) (
    input  logic         clk,
    input  logic         reset,
    input  buf_op_t      op,
    input  logic [W-1:0] target_in,
    output logic         pending,
    output logic [W-1:0] pend_target
);

    buf_state_t state, state_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BUF_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (op)
            BUF_LOAD:  state_nxt = BUF_HELD;
            BUF_CLEAR: state_nxt = BUF_IDLE;
            default:   state_nxt = state;
        endcase
    end

    // A later load while still HELD simply overwrites the buffered target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_target <= '0;
        end else if (op == BUF_LOAD) begin
            pend_target <= target_in;
        end
    end

    assign pending = (state == BUF_HELD);

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: priority next-PC mux, pc register, +4 adder,
// fetch address error check and fetch counter.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned W          = PC_W,
    parameter logic [W-1:0] RESET_PC   = W'(RESET_PC_DEF),
    parameter logic [W-1:0] EXC_VECTOR = W'(EXC_VEC_DEF),
    parameter logic [W-1:0] IM_LO      = W'(IM_LO_DEF),
    parameter logic [W-1:0] IM_HI      = W'(IM_HI_DEF),
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             redirect_valid,
    input  logic [W-1:0]     redirect_target,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [W-1:0]     epc,
    output logic [W-1:0]     pc,
    output logic [W-1:0]     pc_plus4,
    output logic             adel,
    output logic             pending,
    output logic [CNT_W-1:0] fetch_cnt
);

    logic [W-1:0] pend_target;
    logic [W-1:0] pc_nxt;
    logic         pc_load;
    buf_op_t      buf_op;

    pc_redirect_buf #(
        .W (W)
    ) u_redirect_buf (
        .clk         (clk),
        .reset       (reset),
        .op          (buf_op),
        .target_in   (redirect_target),
        .pending     (pending),
        .pend_target (pend_target)
    );

    assign pc_plus4 = pc + W'(4);

    // CP0 requests bypass the stall; a fresh redirect beats a buffered one.
    always_comb begin
        pc_nxt  = pc;
        pc_load = 1'b0;
        buf_op  = BUF_HOLD;
        if (exc_req) begin
            pc_nxt  = EXC_VECTOR;
            pc_load = 1'b1;
            buf_op  = BUF_CLEAR;
        end else if (eret_req) begin
            pc_nxt  = epc;
            pc_load = 1'b1;
            buf_op  = BUF_CLEAR;
        end else if (en && redirect_valid) begin
            pc_nxt  = redirect_target;
            pc_load = 1'b1;
            buf_op  = BUF_CLEAR;
        end else if (en && pending) begin
            pc_nxt  = pend_target;
            pc_load = 1'b1;
            buf_op  = BUF_CLEAR;
        end else if (en) begin
            pc_nxt  = pc_plus4;
            pc_load = 1'b1;
        end else if (redirect_valid) begin
            buf_op  = BUF_LOAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            fetch_cnt <= '0;
        end else if (pc_load) begin
            pc        <= pc_nxt;
            fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
    end

    assign adel = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios then randomized traffic,
// checked against a behavioural model of the fetch PC rules.
module tb_pc_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] p4;
        logic        adel;
        logic        pend;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = '0;
    logic [31:0] pc, pc_plus4, fetch_cnt;
    logic        adel, pending;

    pc_unit #(
        .W (32),
        .CNT_W (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_req         (exc_req),
        .eret_req        (eret_req),
        .epc             (epc),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .adel            (adel),
        .pending         (pending),
        .fetch_cnt       (fetch_cnt)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   started = 1'b0;
    event async_chk;

    // Reference model state
    logic [31:0] m_pc, m_ptgt, m_cnt;
    bit          m_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_top();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("pc", pc, e.pc);
            check("pc_plus4", pc_plus4, e.p4);
            check("adel", {31'd0, adel}, {31'd0, e.adel});
            check("pending", {31'd0, pending}, {31'd0, e.pend});
            check("fetch_cnt", fetch_cnt, e.cnt);
        end
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.pc   = m_pc;
        e.p4   = m_pc + 32'd4;
        e.adel = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h6FFC);
        e.pend = m_pend;
        e.cnt  = m_cnt;
        return e;
    endfunction

    task automatic model_reset();
        m_pc = 32'h3000; m_pend = 0; m_ptgt = 0; m_cnt = 0;
    endtask

    // Drive inputs for the coming edge and record what the pc unit must show after it.
    task automatic drive_and_push(input bit e, input bit rv, input logic [31:0] tgt,
                                  input bit exc, input bit eret, input logic [31:0] ep);
        en = e; redirect_valid = rv; redirect_target = tgt;
        exc_req = exc; eret_req = eret; epc = ep;
        if (exc) begin
            m_pc = 32'h4180; m_pend = 0; m_cnt++;
        end else if (eret) begin
            m_pc = ep; m_pend = 0; m_cnt++;
        end else if (e && rv) begin
            m_pc = tgt; m_pend = 0; m_cnt++;
        end else if (e && m_pend) begin
            m_pc = m_ptgt; m_pend = 0; m_cnt++;
        end else if (e) begin
            m_pc = m_pc + 4; m_cnt++;
        end else if (rv) begin
            m_pend = 1; m_ptgt = tgt;
        end
        sb.push_back(model_snapshot());
    endtask

    task automatic step(input bit e, input bit rv, input logic [31:0] tgt,
                        input bit exc, input bit eret, input logic [31:0] ep);
        @(negedge clk);
        drive_and_push(e, rv, tgt, exc, eret, ep);
    endtask

    // Pulse reset between edges; the reset state must be visible before the next edge.
    task automatic async_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        sb.push_back(model_snapshot());
        ->async_chk;
        #2;
        reset = 1'b0;
        drive_and_push(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (started) compare_top();
        end
    end

    initial begin
        forever begin
            @(async_chk);
            #1;
            compare_top();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 5))
            0: return 32'h3000 + ($urandom_range(0, 16383) << 2) % 32'h4000;
            1: return 32'h3000 + ($urandom_range(0, 4095) << 2);
            2: return 32'h3000 + $urandom_range(0, 32'h3FFF);
            3: return 32'h2FFC;
            4: return 32'h7000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        sb.push_back(model_snapshot());
        ->async_chk;
        started = 1'b1;
        drive_and_push(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Buffered redirect across a stall
        step(0, 1, 32'h3400, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Fresh redirect beats buffered
        step(0, 1, 32'h3400, 0, 0, 0);
        step(1, 1, 32'h3800, 0, 0, 0);

        // Exception while stalled with a pending redirect, then return
        step(0, 1, 32'h3500, 0, 0, 0);
        step(0, 0, 0, 1, 1, 32'h3010);
        step(0, 0, 0, 0, 1, 32'h3010);

        // Address error boundaries
        step(1, 1, 32'h3002, 0, 0, 0);
        step(1, 1, 32'h2FFC, 0, 0, 0);
        step(1, 1, 32'h7000, 0, 0, 0);
        step(1, 1, 32'h6FFC, 0, 0, 0);

        // Async reset while a redirect is pending
        step(0, 1, 32'h3600, 0, 0, 0);
        async_reset();

        // PC wrap
        step(1, 1, 32'hFFFF_FFFC, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, rand_target(),
                     $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, rand_target());
            end
        end

        @(negedge clk);
        en = 0; redirect_valid = 0; exc_req = 0; eret_req = 0;
        repeat (3) begin
            if (sb.size() != 0) @(posedge clk);
        end
        #2;
        started = 1'b0;
        check("sb_drain", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
